// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the Gray coder/decoder pair.
//   GRAY_MAX_W       widest word the helper functions handle
//   bits_per_stage() bits a pipelined decoder resolves per stage, ceil(width/stages)
//   bin2gray()       binary -> Gray
//   gray2bin()       Gray -> binary (MSB-first prefix XOR)
//   popcount()       number of set bits
package gray_pkg;

    localparam int GRAY_MAX_W = 64;

    function automatic int bits_per_stage(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [GRAY_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < GRAY_MAX_W; i++)
            n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/gray_decode_stage.sv
// One pipeline stage of the Gray decoder: resolves binary bits HI down to LO
// (MSB-first) and registers {valid, partial_bin, gray_rem, step_err}.
//   clk, rst_n      clock, async active-low reset
//   en              advance enable (the decoder-wide in_ready)
//   vld_i/vld_o     stage valid in / registered out
//   bin_i/bin_o     partial binary; bits above HI already resolved upstream
//   gray_i/gray_o   Gray bits still to be resolved (resolved bits cleared)
//   err_i/err_o     step error flag travelling with the word
// A stage with HI < LO resolves nothing and simply delays the word.
module gray_decode_stage #(
    parameter int WIDTH = 4,
    parameter int HI    = 3,
    parameter int LO    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] bin_i,
    input  logic [WIDTH-1:0] gray_i,
    input  logic             err_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] gray_o,
    output logic             err_o
);

    // acc[WIDTH] is a constant 0 so the MSB follows the same recurrence
    // (bin[msb] = 0 ^ g[msb]) as every other bit.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] rem;
    logic             unused_acc_msb;

    always_comb begin
        acc = {1'b0, bin_i};
        rem = gray_i;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i <= HI && i >= LO) begin
                acc[i] = acc[i+1] ^ gray_i[i];
                rem[i] = 1'b0;
            end
        end
    end

    assign unused_acc_msb = acc[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_o  <= 1'b0;
            bin_o  <= '0;
            gray_o <= '0;
            err_o  <= 1'b0;
        end else if (en) begin
            vld_o  <= vld_i;
            bin_o  <= acc[WIDTH-1:0];
            gray_o <= rem;
            err_o  <= err_i;
        end
    end

endmodule

// File: rtl/gray_decoder.sv
// Pipelined Gray -> binary decoder with valid/ready on both sides and a
// single-bit-step checker on the accepted input stream.
//   clk, rst_n           clock, async active-low reset
//   gray_in, in_valid    Gray word and its valid
//   in_ready             decoder can accept (transfer on in_valid & in_ready)
//   bin_out, step_err    decoded word and "differed from previous accepted word in >1 bit"
//   out_valid, out_ready output handshake
// Latency is STAGES cycles; one global stall freezes every stage.
module gray_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             step_err
);

    localparam int BPS = bits_per_stage(WIDTH, STAGES);

    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0][WIDTH-1:0] bin_pipe;
    logic [STAGES:0][WIDTH-1:0] gry_pipe;
    logic [STAGES:0]            err_pipe;

    logic [WIDTH-1:0] prev_gray;
    logic             have_prev;
    logic             accept;
    logic             step_err_in;
    logic             unused_gray_rem;

    // The output register is the only place a word can wait, so the whole
    // pipe moves whenever the output slot is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign step_err_in = have_prev &&
                         (popcount(GRAY_MAX_W'(gray_in ^ prev_gray)) > 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray <= '0;
            have_prev <= 1'b0;
        end else if (accept) begin
            prev_gray <= gray_in;
            have_prev <= 1'b1;
        end
    end

    // Stage 0 input: bubbles enter as valid=0 because en is in_ready, not accept.
    assign vld_pipe[0] = in_valid;
    assign bin_pipe[0] = '0;
    assign gry_pipe[0] = gray_in;
    assign err_pipe[0] = step_err_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int HI     = WIDTH - 1 - k * BPS;
        localparam int LO_RAW = WIDTH - (k + 1) * BPS;
        localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;

        gray_decode_stage #(
            .WIDTH (WIDTH),
            .HI    (HI),
            .LO    (LO)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (in_ready),
            .vld_i  (vld_pipe[k]),
            .bin_i  (bin_pipe[k]),
            .gray_i (gry_pipe[k]),
            .err_i  (err_pipe[k]),
            .vld_o  (vld_pipe[k+1]),
            .bin_o  (bin_pipe[k+1]),
            .gray_o (gry_pipe[k+1]),
            .err_o  (err_pipe[k+1])
        );
    end

    assign out_valid = vld_pipe[STAGES];
    assign bin_out   = bin_pipe[STAGES];
    assign step_err  = err_pipe[STAGES];

    // Every bit is resolved by the last stage, so its remainder is always 0.
    assign unused_gray_rem = ^gry_pipe[STAGES];

endmodule

// File: tb/tb_gray_decoder.sv
module tb_gray_decoder;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int W8 = 8;
    localparam int S8 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] gray_in = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] bin_out;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         step_err;

    gray_decoder #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_out   (bin_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .step_err  (step_err)
    );

    logic [W8-1:0] g8_in = '0;
    logic          g8_vld = 1'b0;
    logic          g8_rdy;
    logic [W8-1:0] b8_out;
    logic          v8_out;
    logic          e8_out;

    gray_decoder #(.WIDTH(W8), .STAGES(S8)) u_w8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (g8_in),
        .in_valid  (g8_vld),
        .in_ready  (g8_rdy),
        .bin_out   (b8_out),
        .out_valid (v8_out),
        .out_ready (1'b1),
        .step_err  (e8_out)
    );

    typedef struct {
        logic [W8-1:0] bin;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t q8[$];
    exp_t mon_e;
    exp_t mon8_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   chk_lat = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the WIDTH=4 instance: compares whenever a word leaves.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 32'(bin_out) | 32'h100, 32'h0);
            end else begin
                mon_e = sb_q.pop_front();
                check("bin_out", 32'(bin_out), 32'(mon_e.bin));
                check("step_err", 32'(step_err), 32'(mon_e.err));
                if (chk_lat) check("latency", 32'(cyc - mon_e.cyc), 32'(S));
            end
        end
    end

    // Monitor for the WIDTH=8 / STAGES=3 instance.
    always @(negedge clk) begin
        if (rst_n && v8_out) begin
            if (q8.size() == 0) begin
                check("w8_unexpected_output", 32'(b8_out) | 32'h100, 32'h0);
            end else begin
                mon8_e = q8.pop_front();
                check("w8_bin_out", 32'(b8_out), 32'(mon8_e.bin));
                check("w8_step_err", 32'(e8_out), 32'(mon8_e.err));
                check("w8_latency", 32'(cyc - mon8_e.cyc), 32'(S8));
            end
        end
    end

    // Present one word, wait (bounded) for acceptance, record expectation.
    task automatic send(input logic [W-1:0] g, input logic [W-1:0] b, input logic e);
        int t;
        gray_in  = g;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 32'h0, 32'h1);
        else sb_q.push_back('{bin: W8'(b), err: e, cyc: cyc});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || q8.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", 32'(sb_q.size() + q8.size()), 32'h0);
        idle(1);
    endtask

    function automatic logic [W8-1:0] g2b8(input logic [W8-1:0] g);
        logic [W8-1:0] b;
        b[W8-1] = g[W8-1];
        for (int i = W8 - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W8-1:0] prev8;
        logic [W8-1:0] code8;
        logic          have8;
        logic [W-1:0]  sw;

        // 1. reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_bin_out", 32'(bin_out), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_step_err", 32'(step_err), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        idle(1);

        // 2. single words with gaps; second and third are 2-bit steps
        send(4'b0010, 4'b0011, 1'b0);
        idle(3);
        send(4'b0100, 4'b0111, 1'b1);
        idle(3);
        send(4'b1000, 4'b1111, 1'b1);
        idle(3);

        // 3. full sweep back-to-back, then wrap to 0000
        for (int i = 0; i < 16; i++) begin
            sw = W'(i);
            send(sw ^ (sw >> 1), sw, 1'b0);
        end
        send(4'b0000, 4'b0000, 1'b0);
        drain();

        // 4. backpressure mid-stream (last word is a 2-bit step)
        chk_lat = 1'b0;
        fork
            begin
                send(4'b0001, 4'b0001, 1'b0);
                send(4'b0011, 4'b0010, 1'b0);
                send(4'b0010, 4'b0011, 1'b0);
                send(4'b0110, 4'b0100, 1'b0);
                send(4'b0101, 4'b0110, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'h0);
                    check("stall_out_valid", 32'(out_valid), 32'h1);
                    check("stall_hold", 32'(bin_out), 32'(sb_q[0].bin));
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk_lat = 1'b1;

        // 5. reset with two words in flight; 1000 would be a 4-bit step from 0111
        out_ready = 1'b0;
        send(4'b0100, 4'b0111, 1'b0);
        send(4'b0111, 4'b0101, 1'b1);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_bin_out", 32'(bin_out), 32'h0);
        out_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        idle(1);
        send(4'b1000, 4'b1111, 1'b0);
        drain();

        // 6. WIDTH=8, STAGES=3 stream of 0/1/2-bit steps, one word per cycle
        have8 = 1'b0;
        prev8 = '0;
        for (int n = 0; n < 40; n++) begin
            code8 = prev8;
            for (int f = $urandom_range(0, 2); f > 0; f--)
                code8[$urandom_range(0, W8 - 1)] ^= 1'b1;
            if (n == 0) code8 = 8'hC5;
            g8_in  = code8;
            g8_vld = 1'b1;
            @(negedge clk);
            check("w8_in_ready", 32'(g8_rdy), 32'h1);
            q8.push_back('{bin: g2b8(code8),
                           err: have8 && ($countones(code8 ^ prev8) > 1),
                           cyc: cyc});
            prev8 = code8;
            have8 = 1'b1;
            @(posedge clk);
            #1;
        end
        g8_vld = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
